// File: rtl/change_dispenser_if.sv
// Vend/change handshake between the vending controller and the change
// dispenser: load strobe with counts, drop sensors, and solenoid/status outputs.
interface change_dispenser_if;
    logic       load_i;
    logic       vend_i;
    logic       ten_num_i;
    logic [1:0] five_num_i;
    logic [2:0] one_num_i;
    logic       product_drop_i;
    logic       coin_drop_i;
    logic       clear_i;
    logic       product_motor_o;
    logic       ten_motor_o;
    logic       five_motor_o;
    logic       one_motor_o;
    logic       busy_o;
    logic       done_o;
    logic       fault_o;
    logic [3:0] coins_left_o;

    modport master (
        output load_i, vend_i, ten_num_i, five_num_i, one_num_i,
        output product_drop_i, coin_drop_i, clear_i,
        input  product_motor_o, ten_motor_o, five_motor_o, one_motor_o,
        input  busy_o, done_o, fault_o, coins_left_o
    );

    modport slave (
        input  load_i, vend_i, ten_num_i, five_num_i, one_num_i,
        input  product_drop_i, coin_drop_i, clear_i,
        output product_motor_o, ten_motor_o, five_motor_o, one_motor_o,
        output busy_o, done_o, fault_o, coins_left_o
    );
endinterface

// File: rtl/change_dispenser.sv
// Change dispenser: latches a vend request plus coin counts, then fires the
// product and coin solenoids one item at a time, waiting for drop-sensor
// confirmation of each. A missing confirmation within the timeout parks the
// block in FAULT until cleared. All outputs are registered from next state.
module change_dispenser #(
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    change_dispenser_if.slave bus
);
    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEL   = 3'd1,
        ST_FIRE  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAULT = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ITEM_PRODUCT = 2'd0,
        ITEM_TEN     = 2'd1,
        ITEM_FIVE    = 2'd2,
        ITEM_ONE     = 2'd3
    } item_e;

    state_e          state_r, state_s;
    item_e           item_r, item_s;
    logic            vend_r, vend_s;
    logic            ten_r, ten_s;
    logic [1:0]      five_r, five_s;
    logic [2:0]      one_r, one_s;
    logic [3:0]      coins_left_r, coins_left_s;
    logic [PW-1:0]   pulse_cnt_r, pulse_cnt_s;
    logic [TW-1:0]   tmo_cnt_r, tmo_cnt_s;
    logic            drop_r, drop_s;
    logic            sensor_s;
    logic            drop_hit_s;

    logic            product_motor_r, ten_motor_r, five_motor_r, one_motor_r;
    logic            busy_r, done_r, fault_r;

    // The product has its own sensor; all coin tubes share one.
    assign sensor_s   = (item_r == ITEM_PRODUCT) ? bus.product_drop_i : bus.coin_drop_i;
    assign drop_hit_s = drop_r | sensor_s;

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            item_r       <= ITEM_PRODUCT;
            vend_r       <= 1'b0;
            ten_r        <= 1'b0;
            five_r       <= 2'd0;
            one_r        <= 3'd0;
            coins_left_r <= 4'd0;
            pulse_cnt_r  <= {PW{1'b0}};
            tmo_cnt_r    <= {TW{1'b0}};
            drop_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            item_r       <= item_s;
            vend_r       <= vend_s;
            ten_r        <= ten_s;
            five_r       <= five_s;
            one_r        <= one_s;
            coins_left_r <= coins_left_s;
            pulse_cnt_r  <= pulse_cnt_s;
            tmo_cnt_r    <= tmo_cnt_s;
            drop_r       <= drop_s;
        end
    end

    // Next-state logic: item selection, pulse/timeout counting, delivery bookkeeping.
    always_comb begin
        state_s      = state_r;
        item_s       = item_r;
        vend_s       = vend_r;
        ten_s        = ten_r;
        five_s       = five_r;
        one_s        = one_r;
        coins_left_s = coins_left_r;
        pulse_cnt_s  = pulse_cnt_r;
        tmo_cnt_s    = tmo_cnt_r;
        drop_s       = drop_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.load_i) begin
                    vend_s       = bus.vend_i;
                    ten_s        = bus.ten_num_i;
                    five_s       = bus.five_num_i;
                    one_s        = bus.one_num_i;
                    coins_left_s = {3'b000, bus.ten_num_i} + {2'b00, bus.five_num_i}
                                 + {1'b0, bus.one_num_i};
                    state_s      = ST_SEL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEL: begin
                pulse_cnt_s = {PW{1'b0}};
                tmo_cnt_s   = {TW{1'b0}};
                drop_s      = 1'b0;
                if (vend_r) begin
                    item_s  = ITEM_PRODUCT;
                    state_s = ST_FIRE;
                end else if (ten_r != 1'b0) begin
                    item_s  = ITEM_TEN;
                    state_s = ST_FIRE;
                end else if (five_r != 2'd0) begin
                    item_s  = ITEM_FIVE;
                    state_s = ST_FIRE;
                end else if (one_r != 3'd0) begin
                    item_s  = ITEM_ONE;
                    state_s = ST_FIRE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_FIRE: begin
                drop_s    = drop_hit_s;
                tmo_cnt_s = tmo_cnt_r + 1'b1;
                if (pulse_cnt_r == PULSE_LAST) begin
                    state_s = ST_WAIT;
                end else begin
                    pulse_cnt_s = pulse_cnt_r + 1'b1;
                end
            end
            ST_WAIT: begin
                // A drop seen on the last allowed cycle still counts as delivered.
                if (drop_hit_s) begin
                    drop_s  = 1'b1;
                    state_s = ST_SEL;
                    case (item_r)
                        ITEM_PRODUCT: vend_s = 1'b0;
                        ITEM_TEN: begin
                            ten_s        = ten_r - 1'b1;
                            coins_left_s = coins_left_r - 4'd1;
                        end
                        ITEM_FIVE: begin
                            five_s       = five_r - 2'd1;
                            coins_left_s = coins_left_r - 4'd1;
                        end
                        ITEM_ONE: begin
                            one_s        = one_r - 3'd1;
                            coins_left_s = coins_left_r - 4'd1;
                        end
                        default: vend_s = vend_r;
                    endcase
                end else if (tmo_cnt_r == TMO_LAST) begin
                    state_s = ST_FAULT;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + 1'b1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            ST_FAULT: begin
                if (bus.clear_i) begin
                    state_s      = ST_IDLE;
                    vend_s       = 1'b0;
                    ten_s        = 1'b0;
                    five_s       = 2'd0;
                    one_s        = 3'd0;
                    coins_left_s = 4'd0;
                end else begin
                    state_s = ST_FAULT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Registered outputs decoded from next state so they align with the state they describe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            product_motor_r <= 1'b0;
            ten_motor_r     <= 1'b0;
            five_motor_r    <= 1'b0;
            one_motor_r     <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            fault_r         <= 1'b0;
        end else begin
            product_motor_r <= (state_s == ST_FIRE) && (item_s == ITEM_PRODUCT);
            ten_motor_r     <= (state_s == ST_FIRE) && (item_s == ITEM_TEN);
            five_motor_r    <= (state_s == ST_FIRE) && (item_s == ITEM_FIVE);
            one_motor_r     <= (state_s == ST_FIRE) && (item_s == ITEM_ONE);
            busy_r          <= (state_s != ST_IDLE) && (state_s != ST_FAULT);
            done_r          <= (state_s == ST_DONE);
            fault_r         <= (state_s == ST_FAULT);
        end
    end

    assign bus.product_motor_o = product_motor_r;
    assign bus.ten_motor_o     = ten_motor_r;
    assign bus.five_motor_o    = five_motor_r;
    assign bus.one_motor_o     = one_motor_r;
    assign bus.busy_o          = busy_r;
    assign bus.done_o          = done_r;
    assign bus.fault_o         = fault_r;
    assign bus.coins_left_o    = coins_left_r;
endmodule
